// File: rtl/drag_pkg.sv
// Purpose : shared types, default widths and gear-ratio lookup for the drivetrain integrator.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package drag_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } car_state_t;

   localparam int RPM_W_DEF  = 14;
   localparam int FRAC_W_DEF = 13;

   localparam int RATIO_G0_DEF = 9;
   localparam int RATIO_G1_DEF = 13;
   localparam int RATIO_G2_DEF = 18;
   localparam int RATIO_G3_DEF = 25;

   // Ratios are 5-bit quantities; velocity is therefore RPM_W+5 bits wide.
   function automatic logic [4:0] gear_ratio(input logic [1:0] g,
                                             input int r0, input int r1,
                                             input int r2, input int r3);
      case (g)
         2'd0:    return 5'(r0);
         2'd1:    return 5'(r1);
         2'd2:    return 5'(r2);
         default: return 5'(r3);
      endcase
   endfunction

endpackage

// File: rtl/drivetrain_channel.sv
// Purpose : one car - FSM, shift lag counter, ratio mux, fractional accumulator, saturating position.
// Latency : 1 tick from rpm/gear sample to d_position/position/finished.
// Backpressure: none; the channel advances on every game tick.
// Ports   : clk, rst (sync, active-high, includes race restart), start, rpm, gear in;
//           d_position, position, finished registered out; finish_evt combinational
//           pulse on the tick whose edge makes finished rise (used for race arbitration).
module drivetrain_channel
   import drag_pkg::*;
#(
   parameter int RPM_W       = RPM_W_DEF,
   parameter int FRAC_W      = FRAC_W_DEF,
   parameter int DPOS_W      = 7,
   parameter int POS_W       = 12,
   parameter int TRACK_LEN   = 2000,
   parameter int SHIFT_TICKS = 20,
   parameter int RATIO_G0    = RATIO_G0_DEF,
   parameter int RATIO_G1    = RATIO_G1_DEF,
   parameter int RATIO_G2    = RATIO_G2_DEF,
   parameter int RATIO_G3    = RATIO_G3_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [RPM_W-1:0]  rpm,
   input  logic [1:0]        gear,
   output logic [DPOS_W-1:0] d_position,
   output logic [POS_W-1:0]  position,
   output logic              finished,
   output logic              finish_evt
);

   localparam int VEL_W = RPM_W + 5;
   localparam int SUM_W = VEL_W + 1;
   localparam int PS_W  = POS_W + 1;
   localparam int CNT_W = $clog2(SHIFT_TICKS + 1);

   car_state_t        state;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        gear_q;
   logic [FRAC_W-1:0] acc;

   logic [4:0]        ratio;
   logic [VEL_W-1:0]  velocity;
   logic [SUM_W-1:0]  sum;
   logic [DPOS_W-1:0] d_step;
   logic [PS_W-1:0]   pos_sum;
   logic [POS_W-1:0]  pos_clip;
   logic              reach;
   logic              gear_chg;
   logic              drive;

   always_comb begin
      ratio    = gear_ratio(gear, RATIO_G0, RATIO_G1, RATIO_G2, RATIO_G3);
      velocity = VEL_W'(ratio) * VEL_W'(rpm);
      // The remainder below FRAC_W is carried to the next tick, never dropped.
      sum      = SUM_W'(acc) + SUM_W'(velocity);
      d_step   = DPOS_W'(sum >> FRAC_W);
      pos_sum  = PS_W'(position) + PS_W'(d_step);
      reach    = (pos_sum >= PS_W'(TRACK_LEN));
      pos_clip = reach ? POS_W'(TRACK_LEN) : pos_sum[POS_W-1:0];
      gear_chg = (gear != gear_q);
      // Drive resumes on the tick the lag counter is already at zero, giving
      // exactly SHIFT_TICKS zero-displacement ticks per gear change.
      drive    = !gear_chg &&
                 ((state == ST_RUN) || (state == ST_SHIFT && cnt == '0));
      finish_evt = drive && reach;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         gear_q     <= gear;
         acc        <= '0;
         d_position <= '0;
         position   <= '0;
         finished   <= 1'b0;
      end else begin
         gear_q <= gear;
         unique case (state)
            ST_IDLE: begin
               d_position <= '0;
               if (start) state <= ST_RUN;
            end
            ST_RUN, ST_SHIFT: begin
               if (gear_chg) begin
                  // Entering or re-entering the lag; this tick contributes nothing.
                  state      <= ST_SHIFT;
                  cnt        <= CNT_W'(SHIFT_TICKS - 1);
                  d_position <= '0;
               end else if (!drive) begin
                  cnt        <= cnt - 1'b1;
                  d_position <= '0;
               end else begin
                  acc        <= sum[FRAC_W-1:0];
                  d_position <= d_step;
                  position   <= pos_clip;
                  if (reach) begin
                     finished <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     state    <= ST_RUN;
                  end
               end
            end
            ST_DONE: begin
               d_position <= '0;
            end
            default: begin
               state      <= ST_IDLE;
               d_position <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/drivetrain_integrator.sv
// Purpose : multi-car rpm->track-position integrator with first-finisher/tie arbitration.
// Latency : 1 tick from rpm/gear sample to d_position/position/finished/winner.
// Backpressure: none; every output updates on every game tick.
// Ports   : clk100Hz, rst, reset_status, start, rpm[N_CARS*RPM_W], gear[N_CARS*2] in;
//           d_position, position, finished per car and winner/winner_valid/tie out.
module drivetrain_integrator
   import drag_pkg::*;
#(
   parameter int N_CARS      = 2,
   parameter int RPM_W       = RPM_W_DEF,
   parameter int FRAC_W      = FRAC_W_DEF,
   parameter int DPOS_W      = 7,
   parameter int POS_W       = 12,
   parameter int TRACK_LEN   = 2000,
   parameter int SHIFT_TICKS = 20,
   parameter int RATIO_G0    = RATIO_G0_DEF,
   parameter int RATIO_G1    = RATIO_G1_DEF,
   parameter int RATIO_G2    = RATIO_G2_DEF,
   parameter int RATIO_G3    = RATIO_G3_DEF
) (
   input  logic                     clk100Hz,
   input  logic                     rst,
   input  logic                     reset_status,
   input  logic                     start,
   input  logic [N_CARS*RPM_W-1:0]  rpm,
   input  logic [N_CARS*2-1:0]      gear,
   output logic [N_CARS*DPOS_W-1:0] d_position,
   output logic [N_CARS*POS_W-1:0]  position,
   output logic [N_CARS-1:0]        finished,
   output logic [1:0]               winner,
   output logic                     winner_valid,
   output logic                     tie
);

   logic              restart;
   logic [N_CARS-1:0] finish_evt;
   logic [1:0]        first_idx;
   logic              multi_evt;

   assign restart = rst | reset_status;

   for (genvar k = 0; k < N_CARS; k++) begin : g_car
      drivetrain_channel #(
         .RPM_W(RPM_W), .FRAC_W(FRAC_W), .DPOS_W(DPOS_W), .POS_W(POS_W),
         .TRACK_LEN(TRACK_LEN), .SHIFT_TICKS(SHIFT_TICKS),
         .RATIO_G0(RATIO_G0), .RATIO_G1(RATIO_G1),
         .RATIO_G2(RATIO_G2), .RATIO_G3(RATIO_G3)
      ) u_channel (
         .clk        (clk100Hz),
         .rst        (restart),
         .start      (start),
         .rpm        (rpm[k*RPM_W +: RPM_W]),
         .gear       (gear[2*k +: 2]),
         .d_position (d_position[k*DPOS_W +: DPOS_W]),
         .position   (position[k*POS_W +: POS_W]),
         .finished   (finished[k]),
         .finish_evt (finish_evt[k])
      );
   end

   // Lowest-index finisher this tick; x & (x-1) is non-zero when two or more bits are set.
   always_comb begin
      first_idx = '0;
      for (int k = N_CARS - 1; k >= 0; k--) begin
         if (finish_evt[k]) first_idx = 2'(k);
      end
      multi_evt = |(finish_evt & (finish_evt - N_CARS'(1)));
   end

   always_ff @(posedge clk100Hz) begin
      if (restart) begin
         winner       <= '0;
         winner_valid <= 1'b0;
         tie          <= 1'b0;
      end else if (!winner_valid && (|finish_evt)) begin
         winner       <= first_idx;
         winner_valid <= 1'b1;
         tie          <= multi_evt;
      end
   end

endmodule

// File: tb/tb_drivetrain_integrator.sv
module tb_drivetrain_integrator;

   localparam int N           = 2;
   localparam int RPM_W       = 14;
   localparam int FRAC_W      = 13;
   localparam int DPOS_W      = 7;
   localparam int POS_W       = 12;
   localparam int TRACK_LEN   = 2000;
   localparam int SHIFT_TICKS = 20;

   logic                clk100Hz = 1'b0;
   logic                rst;
   logic                reset_status;
   logic                start;
   logic [N*RPM_W-1:0]  rpm;
   logic [N*2-1:0]      gear;
   logic [N*DPOS_W-1:0] d_position;
   logic [N*POS_W-1:0]  position;
   logic [N-1:0]        finished;
   logic [1:0]          winner;
   logic                winner_valid;
   logic                tie;

   drivetrain_integrator #(.N_CARS(N)) dut (
      .clk100Hz     (clk100Hz),
      .rst          (rst),
      .reset_status (reset_status),
      .start        (start),
      .rpm          (rpm),
      .gear         (gear),
      .d_position   (d_position),
      .position     (position),
      .finished     (finished),
      .winner       (winner),
      .winner_valid (winner_valid),
      .tie          (tie)
   );

   always #5 clk100Hz = ~clk100Hz;

   int checks = 0;
   int errors = 0;

   int ratio_tab[4] = '{9, 13, 18, 25};
   int in_rpm[N];
   int in_gear[N];

   // Reference model: plain integer arithmetic on the race rules.
   int m_run[N], m_done[N], m_lag[N], m_acc[N], m_pos[N], m_d[N], m_fin[N], m_gprev[N];
   int m_winner, m_wv, m_tie;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] dut_d(input int k);
      return 32'(d_position[k*DPOS_W +: DPOS_W]);
   endfunction

   function automatic logic [31:0] dut_pos(input int k);
      return 32'(position[k*POS_W +: POS_W]);
   endfunction

   task automatic model_tick();
      int nnew;
      int first;
      int total;
      if (rst || reset_status) begin
         for (int k = 0; k < N; k++) begin
            m_run[k] = 0; m_done[k] = 0; m_lag[k] = 0; m_acc[k] = 0;
            m_pos[k] = 0; m_d[k] = 0; m_fin[k] = 0; m_gprev[k] = in_gear[k];
         end
         m_winner = 0; m_wv = 0; m_tie = 0;
      end else begin
         nnew  = 0;
         first = -1;
         for (int k = 0; k < N; k++) begin
            if (m_done[k] != 0) begin
               m_d[k] = 0;
            end else if (m_run[k] == 0) begin
               m_d[k] = 0;
               if (start) m_run[k] = 1;
            end else begin
               if (in_gear[k] != m_gprev[k]) m_lag[k] = SHIFT_TICKS;
               if (m_lag[k] > 0) begin
                  m_lag[k]--;
                  m_d[k] = 0;
               end else begin
                  total    = m_acc[k] + ratio_tab[in_gear[k]] * in_rpm[k];
                  m_d[k]   = total / (1 << FRAC_W);
                  m_acc[k] = total % (1 << FRAC_W);
                  m_pos[k] = (m_pos[k] + m_d[k] > TRACK_LEN) ? TRACK_LEN : m_pos[k] + m_d[k];
                  if (m_pos[k] == TRACK_LEN) begin
                     m_done[k] = 1;
                     m_fin[k]  = 1;
                     nnew++;
                     if (first < 0) first = k;
                  end
               end
            end
            m_gprev[k] = in_gear[k];
         end
         if (m_wv == 0 && nnew > 0) begin
            m_winner = first;
            m_wv     = 1;
            m_tie    = (nnew > 1) ? 1 : 0;
         end
      end
   endtask

   // One game tick: drive inputs, advance model at the edge, compare 1 time unit later.
   task automatic step();
      for (int k = 0; k < N; k++) begin
         rpm[k*RPM_W +: RPM_W] = RPM_W'(in_rpm[k]);
         gear[2*k +: 2]        = 2'(in_gear[k]);
      end
      @(posedge clk100Hz);
      model_tick();
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("d_position[%0d]", k), dut_d(k), 32'(m_d[k]));
         check($sformatf("position[%0d]", k), dut_pos(k), 32'(m_pos[k]));
         check($sformatf("finished[%0d]", k), 32'(finished[k]), 32'(m_fin[k]));
      end
      check("winner", 32'(winner), 32'(m_winner));
      check("winner_valid", 32'(winner_valid), 32'(m_wv));
      check("tie", 32'(tie), 32'(m_tie));
   endtask

   task automatic restart_race();
      reset_status = 1'b1;
      step();
      reset_status = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      int zeros;
      int budget;

      rst = 1'b1; reset_status = 1'b0; start = 1'b0;
      for (int k = 0; k < N; k++) begin in_rpm[k] = 0; in_gear[k] = 0; end

      // Reset state
      step(); step();
      check("reset_pos0", dut_pos(0), 0);
      check("reset_wv", 32'(winner_valid), 0);
      rst = 1'b0;

      // Exact carry: 9 * 8192 = 9 units, no remainder
      in_rpm[0] = 8192; in_rpm[1] = 0;
      pulse_start();
      repeat (5) step();
      check("carry_d0", dut_d(0), 9);
      check("carry_pos0", dut_pos(0), 45);
      check("carry_d1_zero_rpm", dut_d(1), 0);

      // Fraction: velocity 4095 -> 0,0,1
      restart_race();
      in_rpm[0] = 455;
      pulse_start();
      step(); check("frac_t1", dut_d(0), 0);
      step(); check("frac_t2", dut_d(0), 0);
      step(); check("frac_t3", dut_d(0), 1);
      check("frac_pos", dut_pos(0), 1);

      // Shift lag
      restart_race();
      in_rpm[0] = 8192; in_gear[0] = 0;
      pulse_start();
      repeat (3) step();
      in_gear[0] = 1;
      zeros = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (dut_d(0) != 0) break;
         zeros++;
      end
      check("shift_zero_ticks", 32'(zeros), 20);
      check("shift_resume_d", dut_d(0), 13);

      // Second change part-way through a lag restarts the full lag
      in_gear[0] = 2;
      repeat (10) step();
      in_gear[0] = 3;
      zeros = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (dut_d(0) != 0) break;
         zeros++;
      end
      check("reshift_zero_ticks", 32'(zeros), 20);
      check("reshift_resume_d", dut_d(0), 25);

      // Restart mid-SHIFT, start in the same tick is overridden
      in_gear[0] = 0;
      repeat (3) step();
      reset_status = 1'b1; start = 1'b1;
      step();
      reset_status = 1'b0; start = 1'b0;
      check("restart_pos0", dut_pos(0), 0);
      check("restart_d0", dut_d(0), 0);
      step();
      check("restart_idle_d0", dut_d(0), 0);
      pulse_start();
      step();
      check("restart_fresh_d0", dut_d(0), 9);

      // Finish: car0 fast, car1 slow
      restart_race();
      in_rpm[0] = 16383; in_gear[0] = 3;
      in_rpm[1] = 8192;  in_gear[1] = 0;
      pulse_start();
      budget = 0;
      while (finished[0] !== 1'b1 && budget < 100) begin step(); budget++; end
      check("finish0_reached", 32'(finished[0]), 1);
      check("finish0_pos_clip", dut_pos(0), 2000);
      check("finish0_winner", 32'(winner), 0);
      check("finish0_wv", 32'(winner_valid), 1);
      check("finish0_tie", 32'(tie), 0);
      budget = 0;
      while (finished[1] !== 1'b1 && budget < 400) begin step(); budget++; end
      check("finish1_reached", 32'(finished[1]), 1);
      check("finish1_winner_kept", 32'(winner), 0);
      check("finish1_pos_clip", dut_pos(1), 2000);

      // Tie: identical stimulus on both cars
      restart_race();
      in_rpm[0] = 12000; in_gear[0] = 2;
      in_rpm[1] = 12000; in_gear[1] = 2;
      pulse_start();
      budget = 0;
      while (finished[0] !== 1'b1 && budget < 300) begin step(); budget++; end
      check("tie_fin", 32'(finished), 3);
      check("tie_flag", 32'(tie), 1);
      check("tie_winner", 32'(winner), 0);
      check("tie_wv", 32'(winner_valid), 1);

      // Randomized races against the model
      for (int r = 0; r < 6; r++) begin
         restart_race();
         for (int k = 0; k < N; k++) begin
            in_rpm[k]  = int'($urandom_range(0, 16383));
            in_gear[k] = int'($urandom_range(0, 3));
         end
         pulse_start();
         for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < N; k++) begin
               if ($urandom_range(0, 15) == 0) in_gear[k] = int'($urandom_range(0, 3));
               if ($urandom_range(0, 31) == 0) in_rpm[k]  = int'($urandom_range(0, 16383));
            end
            start        = ($urandom_range(0, 63) == 0);
            reset_status = ($urandom_range(0, 799) == 0);
            step();
         end
         start = 1'b0; reset_status = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
